// File: rtl/stepper_multi_axis_ctrl.sv
// Multi-axis bipolar stepper controller: relative moves per axis with rate divider, phase sequencer, position counter.
// Latency: first step div+1 clocks after accept; coil pins follow the phase register by one clock.
// Backpressure: cmd_ready is low while the addressed axis is running or disabled; the source holds the command.
// Build option STEPPER_HOLD_EN: enabled idle axes keep their coils energised at the current phase.
module stepper_multi_axis_ctrl #(
   parameter int NUM_AXES = 2,
   parameter int DIV_W    = 23,
   parameter int POS_W    = 16,
   localparam int AXW     = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1
) (
   input  logic                      clk_100mhz,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [AXW-1:0]            cmd_axis,
   input  logic [POS_W-1:0]          cmd_steps,
   input  logic [DIV_W-1:0]          cmd_div,
   input  logic                      cmd_half,
   input  logic [NUM_AXES-1:0]       enable,
   input  logic [NUM_AXES-1:0]       abort,
   output logic [NUM_AXES-1:0]       coil_ap,
   output logic [NUM_AXES-1:0]       coil_an,
   output logic [NUM_AXES-1:0]       coil_bp,
   output logic [NUM_AXES-1:0]       coil_bn,
   output logic [NUM_AXES-1:0]       busy,
   output logic [NUM_AXES-1:0]       done,
   output logic [NUM_AXES*POS_W-1:0] position
);

   localparam logic [0:0]       ST_IDLE  = 1'b0;
   localparam logic [0:0]       ST_RUN   = 1'b1;
   localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

`ifdef STEPPER_HOLD_EN
   localparam logic HOLD = 1'b1;
`else
   localparam logic HOLD = 1'b0;
`endif

   // Bridge pattern {ap,an,bp,bn} for each of the 8 half-step phases.
   function automatic logic [3:0] phase_coils(input logic [2:0] ph);
      case (ph)
         3'd0:    phase_coils = 4'b1010;
         3'd1:    phase_coils = 4'b0010;
         3'd2:    phase_coils = 4'b0110;
         3'd3:    phase_coils = 4'b0100;
         3'd4:    phase_coils = 4'b0101;
         3'd5:    phase_coils = 4'b0001;
         3'd6:    phase_coils = 4'b1001;
         default: phase_coils = 4'b1000;
      endcase
   endfunction

   logic [NUM_AXES-1:0] sel;

   // One-hot decode of the addressed axis; out-of-range indices select nothing.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_AXES; i++) begin
         sel[i] = (cmd_axis == AXW'(i));
      end
   end

   assign cmd_ready = |(sel & enable & ~busy);

   for (genvar g = 0; g < NUM_AXES; g++) begin : g_axis
      logic [0:0]       state;
      logic [2:0]       phase;
      logic [POS_W-1:0] pos;
      logic [POS_W-1:0] rem;
      logic [DIV_W-1:0] ctr;
      logic [DIV_W-1:0] div_q;
      logic             dir;
      logic             half_q;
      logic             done_q;
      logic [3:0]       coil_q;
      logic             accept;
      logic             step_tick;
      logic             stop;
      logic             energise;
      logic [2:0]       step_amt;
      logic [POS_W-1:0] mag;

      assign accept    = cmd_valid & cmd_ready & sel[g];
      assign step_tick = (state == ST_RUN) & (ctr == div_q);
      assign stop      = (state == ST_RUN) & (abort[g] | ~enable[g]);
      assign step_amt  = half_q ? 3'd1 : 3'd2;
      assign mag       = cmd_steps[POS_W-1] ? -cmd_steps : cmd_steps;
      // The done cycle still drives the final phase so the last step is visible on the pins.
      assign energise  = enable[g] & ((state == ST_RUN) | done_q | HOLD);

      // Move sequencer: accept, rate divide, step phase/position, finish or abort.
      always_ff @(posedge clk_100mhz or posedge rst) begin
         if (rst) begin
            state  <= ST_IDLE;
            phase  <= 3'd0;
            pos    <= '0;
            rem    <= '0;
            ctr    <= '0;
            div_q  <= DIV_ONE;
            dir    <= 1'b0;
            half_q <= 1'b0;
            done_q <= 1'b0;
         end else begin
            done_q <= 1'b0;
            if (state == ST_RUN) begin
               if (stop) begin
                  state <= ST_IDLE;
                  rem   <= '0;
               end else if (step_tick) begin
                  ctr   <= '0;
                  phase <= dir ? phase - step_amt : phase + step_amt;
                  pos   <= dir ? pos - POS_ONE : pos + POS_ONE;
                  rem   <= rem - POS_ONE;
                  if (rem == POS_ONE) begin
                     state  <= ST_IDLE;
                     done_q <= 1'b1;
                  end
               end else begin
                  ctr <= ctr + DIV_ONE;
               end
            end else if (accept) begin
               if (cmd_steps == '0) begin
                  done_q <= 1'b1;
               end else begin
                  state  <= ST_RUN;
                  rem    <= mag;
                  dir    <= cmd_steps[POS_W-1];
                  div_q  <= (cmd_div == '0) ? DIV_ONE : cmd_div;
                  half_q <= cmd_half;
                  ctr    <= '0;
                  if (!cmd_half) begin
                     phase[0] <= 1'b0;
                  end
               end
            end
         end
      end

      // Registered bridge drive; disabled axes coast with all switches off.
      always_ff @(posedge clk_100mhz or posedge rst) begin
         if (rst) begin
            coil_q <= 4'b0000;
         end else begin
            coil_q <= energise ? phase_coils(phase) : 4'b0000;
         end
      end

      assign coil_ap[g]                  = coil_q[3];
      assign coil_an[g]                  = coil_q[2];
      assign coil_bp[g]                  = coil_q[1];
      assign coil_bn[g]                  = coil_q[0];
      assign busy[g]                     = (state == ST_RUN);
      assign done[g]                     = done_q;
      assign position[g*POS_W +: POS_W]  = pos;
   end

endmodule

// File: tb/tb_stepper_multi_axis_ctrl.sv
// Bench for stepper_multi_axis_ctrl: directed moves with literal expectations plus randomized traffic,
// every cycle checked against a step-level behavioural model of each axis.
module tb_stepper_multi_axis_ctrl;
   localparam int NA = 2;
   localparam int DW = 23;
   localparam int PW = 16;
`ifdef STEPPER_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic            clk_100mhz = 1'b0;
   logic            rst = 1'b1;
   logic            cmd_valid, cmd_ready;
   logic [0:0]      cmd_axis;
   logic [PW-1:0]   cmd_steps;
   logic [DW-1:0]   cmd_div;
   logic            cmd_half;
   logic [NA-1:0]   enable, abort;
   logic [NA-1:0]   coil_ap, coil_an, coil_bp, coil_bn, busy, done;
   logic [NA*PW-1:0] position;

   stepper_multi_axis_ctrl #(.NUM_AXES(NA), .DIV_W(DW), .POS_W(PW)) dut (
      .clk_100mhz(clk_100mhz), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_axis(cmd_axis),
      .cmd_steps(cmd_steps), .cmd_div(cmd_div), .cmd_half(cmd_half),
      .enable(enable), .abort(abort),
      .coil_ap(coil_ap), .coil_an(coil_an), .coil_bp(coil_bp), .coil_bn(coil_bn),
      .busy(busy), .done(done), .position(position)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   int n_chk = 0;
   int n_fail = 0;
   int edge_n = 0;

   // Behavioural model: one record per axis, advanced once per clock edge.
   int       m_run[NA], m_rem[NA], m_dir[NA], m_half[NA], m_div[NA], m_ctr[NA];
   int       m_phase[NA], m_pos[NA], m_done[NA];
   logic [3:0] m_coil[NA];
   bit       m_acc;

   // Coil-change recorder for the directed sequence checks.
   bit         rec = 1'b0;
   logic [3:0] seq0[$];
   logic [3:0] seq1[$];
   logic [3:0] last_c[NA];

   function automatic logic [3:0] pat(input int ph);
      case (ph)
         0: pat = 4'b1010;  1: pat = 4'b0010;  2: pat = 4'b0110;  3: pat = 4'b0100;
         4: pat = 4'b0101;  5: pat = 4'b0001;  6: pat = 4'b1001;  default: pat = 4'b1000;
      endcase
   endfunction

   function automatic logic [3:0] coils_of(input int a);
      coils_of = {coil_ap[a], coil_an[a], coil_bp[a], coil_bn[a]};
   endfunction

   function automatic logic [PW-1:0] pos_of(input int a);
      pos_of = position[a*PW +: PW];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NA; i++) begin
         m_run[i] = 0; m_rem[i] = 0; m_dir[i] = 0; m_half[i] = 0; m_div[i] = 1;
         m_ctr[i] = 0; m_phase[i] = 0; m_pos[i] = 0; m_done[i] = 0; m_coil[i] = 4'b0000;
      end
      m_acc = 1'b0;
   endtask

   task automatic model_step();
      m_acc = 1'b0;
      for (int i = 0; i < NA; i++) begin
         logic [3:0] nc;
         bit en;
         bit acc;
         int s;
         int d;
         en  = enable[i];
         nc  = (en && (m_run[i] != 0 || m_done[i] != 0 || HOLD)) ? pat(m_phase[i]) : 4'b0000;
         acc = cmd_valid && (int'(cmd_axis) == i) && en && (m_run[i] == 0);
         m_done[i] = 0;
         if (m_run[i] != 0) begin
            if (abort[i] || !en) begin
               m_run[i] = 0;
               m_rem[i] = 0;
            end else if (m_ctr[i] == m_div[i]) begin
               d = (m_dir[i] != 0) ? -1 : 1;
               m_ctr[i]   = 0;
               m_phase[i] = (m_phase[i] + d * ((m_half[i] != 0) ? 1 : 2) + 8) % 8;
               m_pos[i]   = (m_pos[i] + d + 65536) % 65536;
               m_rem[i]   = m_rem[i] - 1;
               if (m_rem[i] == 0) begin
                  m_run[i]  = 0;
                  m_done[i] = 1;
               end
            end else begin
               m_ctr[i] = m_ctr[i] + 1;
            end
         end else if (acc) begin
            m_acc = 1'b1;
            s = int'($signed(cmd_steps));
            if (s == 0) begin
               m_done[i] = 1;
            end else begin
               m_run[i]  = 1;
               m_rem[i]  = (s < 0) ? -s : s;
               m_dir[i]  = (s < 0) ? 1 : 0;
               m_div[i]  = (cmd_div == 0) ? 1 : int'(cmd_div);
               m_half[i] = cmd_half ? 1 : 0;
               m_ctr[i]  = 0;
               if (!cmd_half) m_phase[i] = m_phase[i] - (m_phase[i] % 2);
            end
         end
         m_coil[i] = nc;
      end
   endtask

   // One clock: check ready, advance the model, then compare every output after the edge.
   task automatic tick();
      logic [3:0] c;
      #1;
      chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, enable[cmd_axis] && (m_run[cmd_axis] == 0)});
      model_step();
      @(posedge clk_100mhz);
      @(negedge clk_100mhz);
      edge_n++;
      for (int a = 0; a < NA; a++) begin
         c = coils_of(a);
         chk($sformatf("busy%0d", a), {31'b0, busy[a]}, m_run[a]);
         chk($sformatf("done%0d", a), {31'b0, done[a]}, m_done[a]);
         chk($sformatf("coils%0d", a), {28'b0, c}, {28'b0, m_coil[a]});
         chk($sformatf("pos%0d", a), {16'b0, pos_of(a)}, m_pos[a]);
         if (rec && c != 4'b0000 && c != last_c[a]) begin
            if (a == 0) seq0.push_back(c); else seq1.push_back(c);
            last_c[a] = c;
         end
      end
   endtask

   logic [3:0] exp0[5];
   logic [3:0] exp1[4];
   int acc0, acc1, first0, first1, dedge0, dedge1, dcnt0, dcnt1;

   initial begin
      cmd_valid = 0; cmd_axis = 0; cmd_steps = '0; cmd_div = '0; cmd_half = 0;
      enable = '0; abort = '0; rst = 1'b1;
      model_reset();
      @(negedge clk_100mhz);
      @(negedge clk_100mhz);
      for (int a = 0; a < NA; a++) begin
         chk("rst_busy", {31'b0, busy[a]}, 0);
         chk("rst_done", {31'b0, done[a]}, 0);
         chk("rst_coils", {28'b0, coils_of(a)}, 0);
         chk("rst_pos", {16'b0, pos_of(a)}, 0);
      end
      rst = 1'b0;
      enable = 2'b11;
      tick(); tick();

      // Concurrent moves: axis0 full-step +4 div 3, axis1 half-step -3 div 1.
      exp0 = '{4'b1010, 4'b0110, 4'b0101, 4'b1001, 4'b1010};
      exp1 = '{4'b1010, 4'b1000, 4'b1001, 4'b0001};
      rec = 1'b1; last_c[0] = 4'b0000; last_c[1] = 4'b0000;
      cmd_valid = 1; cmd_axis = 0; cmd_half = 0; cmd_div = 3; cmd_steps = 16'd4;
      tick(); acc0 = edge_n;
      cmd_steps = 16'd2;
      #1 chk("ready_busy_axis0", {31'b0, cmd_ready}, 0);
      tick();
      cmd_axis = 1; cmd_half = 1; cmd_div = 1; cmd_steps = 16'hFFFD;
      #1 chk("ready_idle_axis1", {31'b0, cmd_ready}, 1);
      tick(); acc1 = edge_n;
      cmd_valid = 0;
      first0 = -1; first1 = -1; dedge0 = -1; dedge1 = -1; dcnt0 = 0; dcnt1 = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (first0 < 0 && pos_of(0) != 0) first0 = edge_n;
         if (first1 < 0 && pos_of(1) != 0) first1 = edge_n;
         if (done[0]) begin dcnt0++; dedge0 = edge_n; end
         if (done[1]) begin dcnt1++; dedge1 = edge_n; end
      end
      rec = 1'b0;
      chk("ax0_first_step_lat", first0 - acc0, 4);
      chk("ax1_first_step_lat", first1 - acc1, 2);
      chk("ax0_done_lat", dedge0 - acc0, 16);
      chk("ax1_done_lat", dedge1 - acc1, 6);
      chk("ax0_done_count", dcnt0, 1);
      chk("ax1_done_count", dcnt1, 1);
      chk("ax0_final_pos", {16'b0, pos_of(0)}, 32'h0004);
      chk("ax1_final_pos", {16'b0, pos_of(1)}, 32'hFFFD);
      chk("ax0_seq_len", seq0.size(), 5);
      chk("ax1_seq_len", seq1.size(), 4);
      for (int i = 0; i < 5; i++)
         chk($sformatf("ax0_seq%0d", i), (i < seq0.size()) ? {28'b0, seq0[i]} : 32'hDEAD, {28'b0, exp0[i]});
      for (int i = 0; i < 4; i++)
         chk($sformatf("ax1_seq%0d", i), (i < seq1.size()) ? {28'b0, seq1[i]} : 32'hDEAD, {28'b0, exp1[i]});

      // Abort coincident with the second step tick of a 10-step move.
      cmd_valid = 1; cmd_axis = 0; cmd_half = 0; cmd_div = 3; cmd_steps = 16'd10;
      tick();
      cmd_valid = 0;
      for (int k = 0; k < 7; k++) tick();
      abort = 2'b01;
      tick();
      abort = 2'b00;
      chk("abort_pos", {16'b0, pos_of(0)}, 32'h0005);
      chk("abort_busy", {31'b0, busy[0]}, 0);
      dcnt0 = done[0] ? 1 : 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (done[0]) dcnt0++;
      end
      chk("abort_no_done", dcnt0, 0);

      // Zero-step command: immediate done, never busy.
      cmd_valid = 1; cmd_axis = 1; cmd_half = 1; cmd_div = 5; cmd_steps = 16'd0;
      tick();
      cmd_valid = 0;
      chk("zero_done", {31'b0, done[1]}, 1);
      chk("zero_busy", {31'b0, busy[1]}, 0);
      tick();
      chk("zero_done_clear", {31'b0, done[1]}, 0);

      // div=0 behaves as a 2-clock period.
      cmd_valid = 1; cmd_axis = 1; cmd_half = 1; cmd_div = 0; cmd_steps = 16'd2;
      tick();
      cmd_valid = 0;
      tick();
      chk("div0_pos_e1", {16'b0, pos_of(1)}, 32'hFFFD);
      tick();
      chk("div0_pos_e2", {16'b0, pos_of(1)}, 32'hFFFE);
      tick(); tick();
      chk("div0_pos_e4", {16'b0, pos_of(1)}, 32'hFFFF);
      chk("div0_done", {31'b0, done[1]}, 1);

      // Disabled idle axis coasts.
      enable = 2'b10;
      tick(); tick(); tick();
      chk("disabled_coils", {28'b0, coils_of(0)}, 0);
      enable = 2'b11;
      tick();

      // Randomized traffic; a stalled command is held until accepted.
      for (int k = 0; k < 3000; k++) begin
         int s;
         if (!cmd_valid || m_acc) begin
            s = int'($urandom_range(0, 12)) - 6;
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_axis  = 1'($urandom_range(0, 1));
            cmd_steps = s[15:0];
            cmd_div   = DW'($urandom_range(0, 3));
            cmd_half  = 1'($urandom_range(0, 1));
         end
         abort = {($urandom_range(0, 40) == 0), ($urandom_range(0, 40) == 0)};
         for (int a = 0; a < NA; a++) begin
            if (enable[a]) begin
               if ($urandom_range(0, 99) == 0) enable[a] = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
               enable[a] = 1'b1;
            end
         end
         tick();
      end
      cmd_valid = 0; abort = '0; enable = 2'b11;
      for (int k = 0; k < 200 && (m_run[0] != 0 || m_run[1] != 0); k++) tick();

      // Asynchronous reset in the middle of a move.
      cmd_valid = 1; cmd_axis = 0; cmd_half = 0; cmd_div = 3; cmd_steps = 16'd20;
      tick();
      cmd_valid = 0;
      for (int k = 0; k < 5; k++) tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", {31'b0, busy[0]}, 0);
      chk("arst_pos0", {16'b0, pos_of(0)}, 0);
      chk("arst_pos1", {16'b0, pos_of(1)}, 0);
      chk("arst_coils", {28'b0, coils_of(0)}, 0);
      model_reset();
      @(negedge clk_100mhz);
      rst = 1'b0;
      tick();

      // Position wrap 0x7FFF -> 0x8000.
      cmd_valid = 1; cmd_axis = 0; cmd_half = 0; cmd_div = 0; cmd_steps = 16'h7FFF;
      tick();
      cmd_valid = 0;
      for (int k = 0; k < 70000 && m_run[0] != 0; k++) tick();
      chk("wrap_move_ended", {31'b0, busy[0]}, 0);
      chk("wrap_pre", {16'b0, pos_of(0)}, 32'h7FFF);
      cmd_valid = 1; cmd_steps = 16'd1;
      tick();
      cmd_valid = 0;
      for (int k = 0; k < 4; k++) tick();
      chk("wrap_post", {16'b0, pos_of(0)}, 32'h8000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
